// File: rtl/sram1d_fifo_ctrl.sv
// sram1d_fifo_ctrl: FIFO controller on a single-port SRAM.
// Writes and reads share one SRAM port, so at most one access is granted
// per cycle; a toggle alternates grants when both sides want the port.
// Read data returns one cycle after the read and lands in a 2-entry output
// buffer (OB), which hides the SRAM read latency from the consumer.
// Total capacity is Depth words in SRAM plus 2 in the OB.
module sram1d_fifo_ctrl #(
  parameter int DWidth = 32,
  parameter int AWidth = 10
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic [DWidth-1:0] InData,
  input  logic              InValid,
  output logic              InReady,
  output logic [DWidth-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [AWidth:0]   Count,
  output logic              SRAMEnable,
  output logic              SRAMWrite,
  output logic [AWidth-1:0] SRAMAddress,
  output logic [DWidth-1:0] SRAMDIn,
  input  logic [DWidth-1:0] SRAMDOut
);
  localparam logic [AWidth:0] Depth = {1'b1, {AWidth{1'b0}}};

  logic [AWidth-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AWidth:0]        count_q;
  logic                   last_rd_q;   // 1: most recent granted access was a read
  logic                   rd_vld_q;    // read issued last cycle, SRAMDOut valid now
  logic [1:0][DWidth-1:0] ob_q, ob_d;  // [0] is the oldest entry
  logic [1:0]             ob_cnt_q, ob_cnt_d;
  logic [1:0]             cnt_pop;

  logic not_full, rd_want, wr_want, rd_gnt, wr_gnt, pop;

  // Wants come from registered state (plus InValid); pops are not credited
  // so the OB can never be over-subscribed by in-flight reads.
  assign not_full = (count_q < Depth);
  assign rd_want  = (count_q != '0) &&
                    (({1'b0, ob_cnt_q} + {2'b00, rd_vld_q}) < 3'd2);
  assign wr_want  = InValid & not_full;

  // Arbitration gated by Reset_N so nothing reaches the SRAM during reset.
  assign rd_gnt = Reset_N & rd_want & (~wr_want | ~last_rd_q);
  assign wr_gnt = Reset_N & wr_want & (~rd_want |  last_rd_q);

  // InReady only looks at count and the read grant, never at OutReady.
  assign InReady = Reset_N & not_full & ~rd_gnt;

  assign SRAMEnable  = rd_gnt | wr_gnt;
  assign SRAMWrite   = wr_gnt;
  assign SRAMAddress = rd_gnt ? rd_ptr_q : wr_ptr_q;
  assign SRAMDIn     = InData;

  assign OutValid = (ob_cnt_q != 2'd0);
  assign OutData  = ob_q[0];
  assign Count    = count_q;
  assign pop      = OutValid & OutReady;

  // Output buffer next state: pop shifts the head out, then a returning
  // read is appended behind whatever remains.
  always_comb begin
    ob_d     = ob_q;
    ob_cnt_d = ob_cnt_q;
    cnt_pop  = ob_cnt_q;
    if (pop) begin
      ob_d[0] = ob_q[1];
      cnt_pop = ob_cnt_q - 2'd1;
    end
    ob_cnt_d = cnt_pop;
    if (rd_vld_q) begin
      ob_d[cnt_pop[0]] = SRAMDOut;
      ob_cnt_d         = cnt_pop + 2'd1;
    end
  end

  // Pointers, count and arbitration toggle advance on granted accesses.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_rd_q <= 1'b0;
    end else begin
      if (wr_gnt) begin
        wr_ptr_q <= wr_ptr_q + AWidth'(1);
        count_q  <= count_q + (AWidth+1)'(1);
      end else if (rd_gnt) begin
        rd_ptr_q <= rd_ptr_q + AWidth'(1);
        count_q  <= count_q - (AWidth+1)'(1);
      end
      if (rd_gnt | wr_gnt) last_rd_q <= rd_gnt;
    end
  end

  // Read-return tracking and output buffer; reset drops in-flight data.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      rd_vld_q <= 1'b0;
      ob_q     <= '0;
      ob_cnt_q <= 2'd0;
    end else begin
      rd_vld_q <= rd_gnt;
      ob_q     <= ob_d;
      ob_cnt_q <= ob_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram1d_fifo_ctrl.sv
// Bench for sram1d_fifo_ctrl (AWidth=4): cycle table for the basic
// latency/arbitration path, fill/steady/random runs against a queue
// scoreboard, and a mid-operation reset.
module tb_sram1d_fifo_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int CAP = 18;

  logic          Clock = 1'b0;
  logic          Reset_N = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [DW-1:0] OutData;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [AW:0]   Count;
  logic          SRAMEnable, SRAMWrite;
  logic [AW-1:0] SRAMAddress;
  logic [DW-1:0] SRAMDIn;
  logic [DW-1:0] SRAMDOut = '0;

  sram1d_fifo_ctrl #(.DWidth(DW), .AWidth(AW)) dut (
    .Clock(Clock), .Reset_N(Reset_N),
    .InData(InData), .InValid(InValid), .InReady(InReady),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .Count(Count),
    .SRAMEnable(SRAMEnable), .SRAMWrite(SRAMWrite),
    .SRAMAddress(SRAMAddress), .SRAMDIn(SRAMDIn), .SRAMDOut(SRAMDOut)
  );

  always #5 Clock = ~Clock;

  // single-port SRAM with one-cycle read latency
  logic [DW-1:0] mem [16];
  always @(posedge Clock) begin
    if (SRAMEnable) begin
      if (SRAMWrite) mem[SRAMAddress] <= SRAMDIn;
      else           SRAMDOut <= mem[SRAMAddress];
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] q[$];
  int max_occ = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // scoreboard step, called at the sample point of each cycle
  task automatic observe(output logic pushed, output logic popped);
    pushed = InValid & InReady;
    popped = OutValid & OutReady;
    if (popped) begin
      if (q.size() == 0) chk("pop_from_empty", 64'd1, 64'd0);
      else               chk("out_order", OutData, q.pop_front());
    end
    if (pushed) q.push_back(InData);
    if (q.size() > max_occ) max_occ = q.size();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_N = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_N = 1'b1;
    q.delete();
    max_occ = 0;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          irdy;
    logic          ov;
    logic [DW-1:0] od;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic ps, pp;
    int acc, pops, accs, recv, sent, cyc, phase;
    logic ok, prev_rd;

    // cycle table: push A5 into empty block, second push loses arbitration once
    vt[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 4'd0, 5'd0};
    vt[1] = '{1'b1, 32'h00000011, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd0, 5'd1};
    vt[2] = '{1'b1, 32'h00000011, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 4'd1, 5'd0};
    vt[3] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd1, 5'd1};
    vt[4] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 4'd0, 5'd0};
    vt[5] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h00000011, 1'b0, 1'b0, 4'd0, 5'd0};
    vt[6] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd0};

    // reset state, with a push request pending
    Reset_N = 1'b0; InValid = 1'b1; InData = 32'hDEADBEEF;
    repeat (2) @(negedge Clock);
    #1;
    chk("rst_inready",  InReady, 1'b0);
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_sramen",   SRAMEnable, 1'b0);
    chk("rst_outdata",  OutData, 32'h0);
    chk("rst_count",    Count, 5'd0);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock);
      InValid = vt[i].iv; InData = vt[i].id; OutReady = vt[i].ordy;
      #1;
      chk($sformatf("t%0d_inready", i), InReady, vt[i].irdy);
      chk($sformatf("t%0d_outvalid", i), OutValid, vt[i].ov);
      chk($sformatf("t%0d_sramen", i), SRAMEnable, vt[i].en);
      chk($sformatf("t%0d_count", i), Count, vt[i].cnt);
      if (vt[i].ov) chk($sformatf("t%0d_outdata", i), OutData, vt[i].od);
      if (vt[i].en) begin
        chk($sformatf("t%0d_sramwr", i), SRAMWrite, vt[i].we);
        chk($sformatf("t%0d_addr", i), SRAMAddress, vt[i].addr);
        if (vt[i].we) chk($sformatf("t%0d_din", i), SRAMDIn, vt[i].id);
      end
    end

    // fill with consumer stalled: Depth+2 words fit
    do_reset();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      InValid = 1'b1; InData = 32'h200 + acc; OutReady = 1'b0;
      #1;
      observe(ps, pp);
      if (ps) acc++;
    end
    chk("fill_accepted", acc, CAP);
    chk("fill_inready",  InReady, 1'b0);
    chk("fill_count",    Count, 5'd16);
    chk("fill_outvalid", OutValid, 1'b1);
    chk("fill_head",     OutData, 32'h200);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      InValid = 1'b0; OutReady = 1'b1;
      #1;
      observe(ps, pp);
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("fill_drained", ok, 1'b1);

    // steady push and pop: one word per two cycles
    do_reset();
    pops = 0; accs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clock);
      InValid = 1'b1; InData = 32'h300 + c; OutReady = 1'b1;
      #1;
      observe(ps, pp);
      if (c >= 20 && c < 40) begin
        if (pp) pops++;
        if (ps) accs++;
      end
    end
    chk("steady_pop_rate",  (pops >= 9 && pops <= 11), 1'b1);
    chk("steady_push_rate", (accs >= 9 && accs <= 11), 1'b1);

    // random valid/ready, 48 words, three pointer wraps
    do_reset();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 48 && cyc < 4000) begin
      @(negedge Clock);
      InValid  = (sent < 48) ? 1'($urandom % 2) : 1'b0;
      InData   = 32'h1000 + sent;
      OutReady = 1'($urandom % 2);
      #1;
      observe(ps, pp);
      if (ps) sent++;
      if (pp) recv++;
      cyc++;
    end
    chk("rand_delivered", recv, 48);
    chk("rand_capacity",  (max_occ <= CAP), 1'b1);

    // reset while Count=5 with a read in flight
    do_reset();
    phase = 0; ok = 1'b0; prev_rd = 1'b0; acc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clock);
      if (phase == 2 && prev_rd && Count == 5) begin ok = 1'b1; break; end
      if (phase == 0) begin
        if (Count == 6 && OutValid) begin
          phase = 1; InValid = 1'b0; OutReady = 1'b1;
        end else begin
          InValid = 1'b1; InData = 32'h400 + acc; OutReady = 1'b0;
        end
      end else begin
        phase = 2; InValid = 1'b0; OutReady = 1'b0;
      end
      #1;
      if (InValid && InReady) acc++;
      prev_rd = SRAMEnable & ~SRAMWrite;
    end
    chk("midrst_setup", ok, 1'b1);
    #2;
    Reset_N = 1'b0;
    #1;
    chk("midrst_outvalid", OutValid, 1'b0);
    chk("midrst_inready",  InReady, 1'b0);
    chk("midrst_sramen",   SRAMEnable, 1'b0);
    chk("midrst_count",    Count, 5'd0);
    chk("midrst_outdata",  OutData, 32'h0);
    @(negedge Clock);
    Reset_N = 1'b1;
    #1;
    chk("post_count",    Count, 5'd0);
    chk("post_outvalid", OutValid, 1'b0);
    chk("post_inready",  InReady, 1'b1);
    @(negedge Clock);
    #1;
    chk("post_nocapture", OutValid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram1d_fifo_ctrl.md
SRAM1D_FIFO_CTRL -- requirements
Module: sram1d_fifo_ctrl

Interface
REQ-001 Parameter DWidth, default 32, data word width in bits.
REQ-002 Parameter AWidth, default 10, SRAM address width; SRAM depth is Depth = 2^AWidth words.
REQ-003 Clock  input  1  single clock; all state on rising edge.
REQ-004 Reset_N  input  1  asynchronous, active-low reset.
REQ-005 InData  input  DWidth  push data.
REQ-006 InValid  input  1  push request.
REQ-007 InReady  output  1  push accepted when InValid & InReady.
REQ-008 OutData  output  DWidth  head-of-queue data.
REQ-009 OutValid  output  1  OutData valid.
REQ-010 OutReady  input  1  pop when OutValid & OutReady.
REQ-011 Count  output  AWidth+1  words currently held in SRAM, excluding the output buffer.
REQ-012 SRAMEnable  output  1  single-port SRAM enable.
REQ-013 SRAMWrite  output  1  1 = write, 0 = read.
REQ-014 SRAMAddress  output  AWidth  SRAM word address.
REQ-015 SRAMDIn  output  DWidth  SRAM write data.
REQ-016 SRAMDOut  input  DWidth  SRAM read data, valid one cycle after a read-enable cycle.

Function
REQ-017 The block SHALL be a FIFO built on one single-port SRAM, so at most one SRAM access (read or write) occurs per cycle.
REQ-018 Write pointer WrPtr and read pointer RdPtr SHALL each be AWidth bits wide and wrap naturally from Depth-1 to 0.
REQ-019 The output buffer SHALL hold 2 entries; ReadWant = (Count>0) & (OB occupancy + reads in flight < 2), computed from registered state only.
REQ-020 WriteWant = InValid & (Count < Depth).
REQ-021 Arbitration: a lone want is granted; if both are asserted, write is granted when toggle LastRd=1 and read when LastRd=0; LastRd updates only on granted accesses.
REQ-022 InReady = (Count < Depth) & ~(read granted this cycle); InReady SHALL NOT depend combinationally on OutReady.
REQ-023 Write grant drives SRAMEnable=1, SRAMWrite=1, SRAMAddress=WrPtr, SRAMDIn=InData, and increments WrPtr.
REQ-024 Read grant drives SRAMEnable=1, SRAMWrite=0, SRAMAddress=RdPtr, and increments RdPtr; SRAMDOut is captured into the output buffer at the end of the next cycle.
REQ-025 Count is +1 on a write grant and -1 on a read grant; both never occur in the same cycle.
REQ-026 The output buffer SHALL accept a capture and a pop in the same cycle without loss; OutData is always the oldest entry.
REQ-027 Latency: a push accepted in cycle T into an empty block SHALL appear as OutValid=1 in cycle T+3.
REQ-028 When idle (no grant), SRAMEnable=0 and SRAMAddress/SRAMDIn are don't-care.
REQ-029 Full: Count==Depth forces InReady=0; reads continue. Empty: Count==0 and OB empty gives OutValid=0.
REQ-030 Total capacity is Depth+2 words; data order is strictly preserved across pointer wrap.

Reset
REQ-031 While Reset_N=0, the block SHALL hold WrPtr=RdPtr=0, Count=0, LastRd=0, OB empty, no read in flight, OutValid=0, InReady=0, SRAMEnable=0, and OutData=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and in-flight data immediately; a returning SRAMDOut SHALL NOT be captured.
REQ-033 InReady SHALL be 1 in the first cycle after Reset_N deasserts.

Verification
REQ-034 Reset, then push 0xA5A5A5A5 at T0 -> write to addr 0 at T0, read of addr 0 at T1, OutValid=1 with OutData=0xA5A5A5A5 at T3.
REQ-035 AWidth=4, OutReady=0, continuous push -> 18 words accepted, then InReady=0, Count=16, OutValid=1.
REQ-036 InValid=1 and OutReady=1 held steadily -> reads and writes alternate, throughput of 1 word per 2 cycles, output sequence equals input sequence.
REQ-037 AWidth=4, random InValid/OutReady with 48 incrementing words -> all 48 words delivered in order across 3 pointer wraps, with no SRAM access collision.
REQ-038 Reset_N pulsed low while Count=5 with a read in flight -> outputs drop to reset values asynchronously; after release, Count=0, OutValid=0 and InReady=1.
